// File: rtl/fifo_stream_reader.sv
// Reads words from a same-clock FIFO into a 3-entry in-order buffer and presents them
// as a valid/ready stream. Read issue reserves a buffer slot for the word in flight.
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [CNT_WIDTH-1:0]  xfer_cnt,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [1:0]            occ;
    logic [1:0]            occ_next;
    logic [1:0]            wr_idx;
    logic                  inf;
    logic                  pop;
    logic [DATA_WIDTH-1:0] slot      [3];
    logic [DATA_WIDTH-1:0] slot_next [3];

    assign pop     = m_valid && m_ready;
    assign m_valid = (occ != 2'd0);
    assign m_data  = slot[0];
    assign busy    = m_valid || inf;

    // Counting the in-flight word against capacity guarantees it always has a slot,
    // so the read strobe never needs to look at m_ready.
    assign fifo_rd_en = !rst && en && !fifo_empty &&
                        (({1'b0, occ} + {2'b00, inf}) < 3'd3);

    always_comb begin
        slot_next = slot;
        occ_next  = occ;
        wr_idx    = occ;
        if (pop) begin
            for (int unsigned i = 0; i < 2; i++) begin
                slot_next[i] = slot[i + 1];
            end
            occ_next = occ - 2'd1;
            wr_idx   = occ - 2'd1;
        end
        if (inf) begin
            slot_next[wr_idx] = fifo_dout;
            occ_next          = occ_next + 2'd1;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (en) state_next = RUN;
            RUN:     if (!en) state_next = busy ? DRAIN : IDLE;
            DRAIN: begin
                if (en)        state_next = RUN;
                else if (!busy) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            occ      <= '0;
            inf      <= 1'b0;
            xfer_cnt <= '0;
            for (int unsigned i = 0; i < 3; i++) begin
                slot[i] <= '0;
            end
        end else begin
            state <= state_next;
            occ   <= occ_next;
            inf   <= fifo_rd_en;
            slot  <= slot_next;
            if (pop) xfer_cnt <= xfer_cnt + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Randomized bench for fifo_stream_reader: a source FIFO model plus a queue-based
// reference of words read but not yet handed off, compared every cycle.
module tb_fifo_stream_reader;

    localparam int DW = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic          fifo_empty = 1'b1;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_dout = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic [CW-1:0] xfer_cnt;
    logic          busy;

    fifo_stream_reader #(
        .DATA_WIDTH(DW),
        .CNT_WIDTH (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en),
        .fifo_dout (fifo_dout),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .xfer_cnt  (xfer_cnt),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        int            c;
    } ent_t;

    logic [DW-1:0] src[$];
    ent_t          q[$];
    int            cnt = 0;
    int            cyc = 0;
    bit            armed = 1'b0;

    int checks = 0;
    int errors = 0;

    int n_rd, n_hs, first_rd, first_v, first_hs, last_hs;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clr_stats();
        n_rd = 0; n_hs = 0; first_rd = -1; first_v = -1; first_hs = -1; last_hs = -1;
    endtask

    task automatic cycle(input logic r, input logic e, input logic mr);
        bit            exp_rd, exp_v, rd, hs_m;
        logic [DW-1:0] w;
        rst = r; en = e; m_ready = mr;
        fifo_empty = (src.size() == 0);
        @(negedge clk);
        exp_rd = !r && e && !fifo_empty && (q.size() < 3);
        exp_v  = (q.size() > 0) && (q[0].c + 2 <= cyc);
        chk("rd_en", {31'd0, fifo_rd_en}, {31'd0, exp_rd});
        if (armed) begin
            chk("m_valid", {31'd0, m_valid}, {31'd0, exp_v});
            chk("busy", {31'd0, busy}, {31'd0, q.size() != 0});
            chk("xfer_cnt", {28'd0, xfer_cnt}, cnt % 16);
            if (exp_v) chk("m_data", {24'd0, m_data}, {24'd0, q[0].d});
        end
        rd   = fifo_rd_en;
        hs_m = exp_v && mr && !r;
        if (rd) begin
            n_rd++;
            if (first_rd < 0) first_rd = cyc;
        end
        if (m_valid && first_v < 0) first_v = cyc;
        if (hs_m) begin
            n_hs++;
            if (first_hs < 0) first_hs = cyc;
            last_hs = cyc;
        end
        @(posedge clk);
        w = DW'($urandom);
        if (rd && src.size() > 0) w = src.pop_front();
        if (r) begin
            q.delete();
            cnt   = 0;
            armed = 1'b1;
        end else begin
            if (hs_m) begin
                void'(q.pop_front());
                cnt++;
            end
            if (rd) q.push_back('{d: w, c: cyc});
        end
        #1;
        fifo_dout = rd ? w : DW'($urandom);
        cyc++;
    endtask

    initial begin
        clr_stats();
        cycle(1'b1, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, 1'b0);
        chk("reset m_valid", {31'd0, m_valid}, 32'd0);
        chk("reset m_data", {24'd0, m_data}, 32'd0);
        chk("reset xfer_cnt", {28'd0, xfer_cnt}, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);

        // streaming 0x01..0x10
        for (int i = 1; i <= 16; i++) src.push_back(DW'(i));
        clr_stats();
        for (int i = 0; i < 22; i++) cycle(1'b0, 1'b1, 1'b1);
        chk("stream latency", first_v - first_rd, 32'd2);
        chk("stream words", n_hs, 32'd16);
        chk("stream back-to-back", last_hs - first_hs, 32'd15);
        chk("stream xfer_cnt wrap", {28'd0, xfer_cnt}, 32'd0);
        chk("stream busy end", {31'd0, busy}, 32'd0);

        src.push_back(8'h11);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b1);
        chk("17 handshakes xfer_cnt", {28'd0, xfer_cnt}, 32'd1);

        // backpressure
        for (int i = 1; i <= 8; i++) src.push_back(DW'(i));
        clr_stats();
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b0);
        chk("bp reads", n_rd, 32'd3);
        chk("bp head", {24'd0, m_data}, 32'h01);
        chk("bp valid", {31'd0, m_valid}, 32'd1);
        clr_stats();
        for (int i = 0; i < 15; i++) cycle(1'b0, 1'b1, 1'b1);
        chk("bp delivered", n_hs, 32'd8);

        // empty FIFO
        clr_stats();
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, 1'b1);
        chk("empty reads", n_rd, 32'd0);
        chk("empty valid seen", first_v, 32'hFFFF_FFFF);

        // drain: en drops right after the third read pulse
        for (int i = 0; i < 10; i++) src.push_back(DW'(8'h40 + i));
        clr_stats();
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0);
        chk("drain setup reads", n_rd, 32'd3);
        clr_stats();
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 1'b1);
        chk("drain reads", n_rd, 32'd0);
        chk("drain delivered", n_hs, 32'd3);
        chk("drain busy end", {31'd0, busy}, 32'd0);

        // reset with occ=2 and a word in flight
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        chk("mid-reset m_valid", {31'd0, m_valid}, 32'd0);
        chk("mid-reset xfer_cnt", {28'd0, xfer_cnt}, 32'd0);
        chk("mid-reset busy", {31'd0, busy}, 32'd0);
        clr_stats();
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b1);
        chk("mid-reset late word", n_hs, 32'd0);
        chk("mid-reset valid seen", first_v, 32'hFFFF_FFFF);
        src.delete();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                int n = int'($urandom_range(1, 4));
                for (int k = 0; k < n; k++) src.push_back(DW'($urandom));
            end
            cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) != 0),
                  ($urandom_range(0, 2) != 0));
        end
        src.delete();
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 1'b1);
        chk("final busy", {31'd0, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
